// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_serial_adder_ctrl_pkg;

    // Width of one arithmetic step.
    localparam int unsigned NIBBLE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count nibble steps 0..nib-1 (never narrower than one bit).
    function automatic int unsigned idx_width(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle between producers, the controller and consumers.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    // Controller side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// Combinational 4-bit ripple adder shared across all nibble steps.
module four_bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    // Zero-extend to five bits so the carry lands in the top bit.
    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through a single shared adder.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W = idx_width(NIB);

    // Reject widths the nibble sequencing cannot handle.
    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_cout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_s_nib;
    logic                w_cout;
    logic                w_last;

    assign w_a_nib = r_a[NIBBLE_W-1:0];
    assign w_b_nib = r_b[NIBBLE_W-1:0];
    assign w_last  = (r_idx == IDX_W'(NIB - 1));

    four_bit_adder u_adder (w_a_nib, w_b_nib, r_carry, w_s_nib, w_cout);

    // Sequencer: accept operands, step one nibble per edge, hold result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        // Subtraction is a + ~b + 1: invert b here, force carry-in to 1.
                        r_b        <= bus.b ^ {WIDTH{bus.sub}};
                        r_carry    <= bus.sub ? 1'b1 : bus.cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_sum   <= {w_s_nib, r_sum[WIDTH-1:NIBBLE_W]};
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        // On the last step the low nibbles hold the original A MSB
                        // and the post-invert B MSB.
                        r_cout      <= w_cout;
                        r_ovf       <= (w_a_nib[NIBBLE_W-1] == w_b_nib[NIBBLE_W-1]) &&
                                       (w_s_nib[NIBBLE_W-1] != w_a_nib[NIBBLE_W-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl with directed vectors.
module tb_nibble_serial_adder_ctrl;
    localparam int unsigned WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pop and compare whenever a result is handed over.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", 32'(bus_if.sum), 32'(e.sum));
                    chk("cout", 32'(bus_if.cout), 32'(e.cout));
                    chk("overflow", 32'(bus_if.overflow), 32'(e.ovf));
                end
            end
        end
    end

    // Hard stop if something hangs despite bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Present one operand set and queue its expected result; returns after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [15:0] es, input logic ec, input logic eo);
        int t;
        t = 0;
        while (!bus_if.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("wait_in_ready_timeout", 32'd1, 32'd0);
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.cin      = cin;
        bus_if.sub      = sub;
        bus_if.in_valid = 1'b1;
        exp_q.push_back('{sum: es, cout: ec, ovf: eo});
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Wait (bounded) until the controller is idle again.
    task automatic wait_idle();
        int t;
        t = 0;
        while (!bus_if.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int t;
        n_checks = 0;
        n_pass   = 0;
        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.cin       = 1'b0;
        bus_if.sub       = 1'b0;
        bus_if.out_ready = 1'b1;
        rst = 1'b1;
        #3;
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_sum", 32'(bus_if.sum), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus_if.out_valid), 32'd0);

        // Basic add with latency check: out_valid rises on the 4th edge after accept.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        chk("calc_busy", 32'(bus_if.busy), 32'd1);
        chk("calc_in_ready", 32'(bus_if.in_ready), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk("latency_early", 32'(bus_if.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        chk("latency_edge4", 32'(bus_if.out_valid), 32'd1);
        wait_idle();

        // Carry chain and signed overflow on add.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        // Subtract (cin ignored).
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        wait_idle();

        // Back-pressure: result held while out_ready=0; stray in_valid ignored.
        bus_if.out_ready = 1'b0;
        issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        bus_if.a        = 16'hAAAA;
        bus_if.in_valid = 1'b1;
        t = 0;
        while (!bus_if.out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) chk("wait_out_valid_timeout", 32'd1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_sum", 32'(bus_if.sum), 32'h1000);
            chk("hold_cout", 32'(bus_if.cout), 32'd0);
            chk("hold_overflow", 32'(bus_if.overflow), 32'd0);
            chk("hold_in_ready", 32'(bus_if.in_ready), 32'd0);
            chk("hold_out_valid", 32'(bus_if.out_valid), 32'd1);
            if (i == 1) bus_if.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus_if.in_ready), 32'd1);
        issue(16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0);
        wait_idle();

        // Reset mid-operation: no result, outputs cleared asynchronously.
        bus_if.a        = 16'h1111;
        bus_if.b        = 16'h2222;
        bus_if.cin      = 1'b0;
        bus_if.sub      = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("abort_sum", 32'(bus_if.sum), 32'd0);
        chk("abort_cout", 32'(bus_if.cout), 32'd0);
        chk("abort_overflow", 32'(bus_if.overflow), 32'd0);
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_in_ready", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("post_abort_out_valid", 32'(bus_if.out_valid), 32'd0);
        end
        issue(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
